// File: rtl/trap_unit_if.sv
// Trap unit bus: interrupt lines, exception/return requests, CSR access port
// and trap redirect handshake between a core pipeline and trap_unit.
interface trap_unit_if #(
  parameter int NIRQ = 4
);
  // Interrupt sources (level)
  logic [NIRQ-1:0] irq;
  logic            mtip;
  logic            msip;
  logic            meip;
  // Synchronous exception report
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [31:0]     exc_tval;
  // Pipeline context
  logic [31:0]     pc;
  logic            boundary;
  logic            mret;
  // CSR access
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_wdata;
  logic [31:0]     csr_rdata;
  // Trap redirect / return
  logic            trap_req;
  logic            trap_ack;
  logic [31:0]     trap_target;
  logic            ret_pulse;
  logic [31:0]     ret_pc;
  // CSR state visibility
  logic [31:0]     mcause;
  logic [31:0]     mepc;
  logic [31:0]     mtval;
  logic [31:0]     mip;
  logic [31:0]     mie;

  // Core side
  modport master (
    output irq, mtip, msip, meip,
    output exc_valid, exc_cause, exc_tval,
    output pc, boundary, mret,
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata,
    input  trap_req, trap_target, ret_pulse, ret_pc,
    output trap_ack,
    input  mcause, mepc, mtval, mip, mie
  );

  // Trap unit side
  modport slave (
    input  irq, mtip, msip, meip,
    input  exc_valid, exc_cause, exc_tval,
    input  pc, boundary, mret,
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata,
    output trap_req, trap_target, ret_pulse, ret_pc,
    input  trap_ack,
    output mcause, mepc, mtval, mip, mie
  );
endinterface

// File: rtl/trap_unit.sv
// Machine-mode trap unit: registers interrupt pending bits, arbitrates
// exceptions and prioritised interrupts, holds the trap CSRs and drives a
// trap_req/trap_ack redirect handshake plus a one-cycle mret return pulse.
// Optional feature: define TRAP_VECTORED_EN to enable vectored mtvec mode
// (mtvec[1:0]=01 sends interrupt traps to base+4*cause).
module trap_unit #(
  parameter int          NIRQ        = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input logic        clk,
  input logic        reset,
  trap_unit_if.slave bus
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;

  // Writable mie bits: MSIE, MTIE, MEIE and one bit per platform line.
  localparam logic [31:0] MIE_MASK =
    32'h0000_0888 | (((32'h1 << NIRQ) - 32'h1) << 16);

  // Legalise an mtvec value: mode field only survives when vectoring exists.
  function automatic logic [31:0] mtvec_legal(input logic [31:0] v);
`ifdef TRAP_VECTORED_EN
    return {v[31:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
    return {v[31:2], 2'b00};
`endif
  endfunction

  state_t      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [31:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic        ret_pulse_q;

  logic [31:0] mip_next;
  logic [31:0] pending;
  logic [4:0]  irq_cause;
  logic        irq_any;
  logic        in_idle, take_exc, take_irq, take_trap, take_mret;
  logic        csr_locked;
  logic        unused_pc_bits;

  // Low pc bits are dropped when forming mepc.
  assign unused_pc_bits = ^bus.pc[1:0];

  // Gather raw interrupt levels into mip layout.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mip_next     = '0;
    mip_next[3]  = bus.msip;
    mip_next[7]  = bus.mtip;
    mip_next[11] = bus.meip;
    for (int i = 0; i < NIRQ; i++) mip_next[16+i] = bus.irq[i];
  end

  assign pending = mip_q & mie_q;
  assign irq_any = |pending;

  // Fixed priority: MEI, MSI, MTI, then platform lines lowest index first.
  always_comb begin
    irq_cause = '0;
    if (pending[11])     irq_cause = 5'd11;
    else if (pending[3]) irq_cause = 5'd3;
    else if (pending[7]) irq_cause = 5'd7;
    else begin
      // Scan downward so the lowest pending line is the last (winning) write.
      for (int i = NIRQ - 1; i >= 0; i--)
        if (pending[16+i]) irq_cause = 5'(16 + i);
    end
  end

  // Trap/return decisions; only taken from IDLE, nothing queues in REQ.
  // An interrupt that qualifies alongside mret wins; mret is dropped like
  // it is for an exception.
  assign in_idle   = (state_q == S_IDLE);
  assign take_exc  = in_idle && bus.exc_valid;
  assign take_irq  = in_idle && !bus.exc_valid && bus.boundary &&
                     mstatus_mie_q && irq_any;
  assign take_trap = take_exc || take_irq;
  assign take_mret = in_idle && bus.mret && !take_trap;

  // mstatus/mepc/mcause/mtval belong to the trap logic while a trap or
  // return is being committed and while a request is outstanding.
  assign csr_locked = take_trap || take_mret || (state_q == S_REQ);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: commit enters REQ, an ack releases it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take_trap)    state_d = S_REQ;
      S_REQ:   if (bus.trap_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request is raised for the whole REQ state.
  always_comb begin
    bus.trap_req = (state_q == S_REQ);
  end

  // CSR and trap-record registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= mtvec_legal(RESET_MTVEC);
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mip_q          <= '0;
      ret_pulse_q    <= 1'b0;
    end else begin
      mip_q       <= mip_next;
      ret_pulse_q <= take_mret;

      if (bus.csr_we && bus.csr_addr == A_MIE)   mie_q   <= bus.csr_wdata & MIE_MASK;
      if (bus.csr_we && bus.csr_addr == A_MTVEC) mtvec_q <= mtvec_legal(bus.csr_wdata);

      if (take_trap) begin
        mepc_q         <= {bus.pc[31:2], 2'b00};
        mcause_q       <= take_exc ? {28'h0, bus.exc_cause} : {1'b1, 26'h0, irq_cause};
        mtval_q        <= take_exc ? bus.exc_tval : 32'h0;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (take_mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (bus.csr_we && !csr_locked) begin
        case (bus.csr_addr)
          A_MSTATUS: begin
            mstatus_mie_q  <= bus.csr_wdata[3];
            mstatus_mpie_q <= bus.csr_wdata[7];
          end
          A_MEPC:    mepc_q   <= {bus.csr_wdata[31:2], 2'b00};
          A_MCAUSE:  mcause_q <= bus.csr_wdata;
          A_MTVAL:   mtval_q  <= bus.csr_wdata;
          default:   ;
        endcase
      end
    end
  end

  // Combinational CSR read; unmapped addresses read zero.
  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_addr)
      A_MSTATUS: bus.csr_rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      A_MIE:     bus.csr_rdata = mie_q;
      A_MTVEC:   bus.csr_rdata = mtvec_q;
      A_MEPC:    bus.csr_rdata = mepc_q;
      A_MCAUSE:  bus.csr_rdata = mcause_q;
      A_MTVAL:   bus.csr_rdata = mtval_q;
      A_MIP:     bus.csr_rdata = mip_q;
      default:   bus.csr_rdata = '0;
    endcase
  end

  // Redirect target: base, or base+4*cause for vectored interrupt traps.
  always_comb begin
    bus.trap_target = {mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01 && mcause_q[31])
      bus.trap_target = {mtvec_q[31:2], 2'b00} + {25'h0, mcause_q[4:0], 2'b00};
`endif
  end

  assign bus.ret_pulse = ret_pulse_q;
  assign bus.ret_pc    = mepc_q;
  assign bus.mcause    = mcause_q;
  assign bus.mepc      = mepc_q;
  assign bus.mtval     = mtval_q;
  assign bus.mip       = mip_q;
  assign bus.mie       = mie_q;

endmodule
